// File: rtl/execution_muldiv_if.sv
// Execution-stage bus between ID/EX (master side) and the EX stage (slave side).
// Carries the clock enable, the presented instruction and operands, the stall
// back to the front end, and the EX/MEM result register contents.
interface execution_muldiv_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_ADDR = 5
);
  logic                clk_en;
  logic                i_valid;
  logic                i_flush;
  logic                i_is_md;
  logic [2:0]          i_funct3;
  logic [XLEN-1:0]     i_rs1;
  logic [XLEN-1:0]     i_rs2;
  logic [XLEN-1:0]     i_alu_result;
  logic                i_reg_wr;
  logic [REG_ADDR-1:0] i_rd;

  logic                o_stall;
  logic                o_busy;
  logic                o_valid;
  logic [XLEN-1:0]     o_result;
  logic                o_reg_wr;
  logic [REG_ADDR-1:0] o_rd;

  // Pipeline side: presents instructions, consumes stall and results.
  modport master (
    output clk_en, i_valid, i_flush, i_is_md, i_funct3, i_rs1, i_rs2,
           i_alu_result, i_reg_wr, i_rd,
    input  o_stall, o_busy, o_valid, o_result, o_reg_wr, o_rd
  );

  // Execution stage side.
  modport slave (
    input  clk_en, i_valid, i_flush, i_is_md, i_funct3, i_rs1, i_rs2,
           i_alu_result, i_reg_wr, i_rd,
    output o_stall, o_busy, o_valid, o_result, o_reg_wr, o_rd
  );
endinterface

// File: rtl/execution_muldiv.sv
// Execution stage: passes single-cycle ALU results into the EX/MEM register and
// runs RV32M/RV64M multiply/divide ops iteratively (one radix-2 step per enabled
// edge, fixed XLEN+1 edge latency) while holding the front end with o_stall.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    execution_muldiv_if.slave: clk_en, instruction/operands in,
//          o_stall (combinational), o_busy and EX/MEM result (registered) out
module execution_muldiv #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  execution_muldiv_if.slave   bus
);

  localparam int unsigned DW    = 2 * XLEN;
  localparam int unsigned CNT_W = (XLEN > 2) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;

  // Iterative datapath state
  logic [CNT_W-1:0]    cnt;
  logic [XLEN-1:0]     op_b;
  logic [DW-1:0]       acc;
  logic                neg_q;
  logic                neg_r;
  logic [2:0]          md_f3;
  logic [REG_ADDR-1:0] md_rd;
  logic                md_reg_wr;

  // EX/MEM register
  logic                valid_q;
  logic                reg_wr_q;
  logic [XLEN-1:0]     result_q;
  logic [REG_ADDR-1:0] rd_q;
  logic                busy_q;

  // Output-comb controls and next EX/MEM values
  logic                accept;
  logic                step;
  logic                stall;
  logic                valid_d;
  logic                reg_wr_d;
  logic [XLEN-1:0]     result_d;
  logic [REG_ADDR-1:0] rd_d;

  logic                last_step;
  assign last_step = (cnt == CNT_W'(XLEN - 1));

  // Operand conditioning at accept: signedness per funct3, magnitudes
  logic            signed_a;
  logic            signed_b;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (bus.i_funct3)
      3'b001: begin signed_a = 1'b1; signed_b = 1'b1; end // MULH
      3'b010: begin signed_a = 1'b1; end                  // MULHSU
      3'b100: begin signed_a = 1'b1; signed_b = 1'b1; end // DIV
      3'b110: begin signed_a = 1'b1; signed_b = 1'b1; end // REM
      default: ;
    endcase
    a_neg  = signed_a & bus.i_rs1[XLEN-1];
    b_neg  = signed_b & bus.i_rs2[XLEN-1];
    b_zero = (bus.i_rs2 == '0);
    abs_a  = a_neg ? XLEN'(-bus.i_rs1) : bus.i_rs1;
    abs_b  = b_neg ? XLEN'(-bus.i_rs2) : bus.i_rs2;
  end

  // Shift-add multiply step: acc = {partial product, remaining multiplier bits}
  logic [XLEN:0]   mul_sum;
  logic [DW-1:0]   mul_next;
  always_comb begin
    mul_sum  = {1'b0, acc[DW-1:XLEN]} + ({1'b0, op_b} & {(XLEN+1){acc[0]}});
    mul_next = {mul_sum, acc[XLEN-1:1]};
  end

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_new;
  logic [DW-1:0]   div_next;
  always_comb begin
    rem_sh   = acc[DW-1:XLEN-1];
    rem_ge   = (rem_sh >= {1'b0, op_b});
    rem_new  = rem_ge ? XLEN'(rem_sh - {1'b0, op_b}) : rem_sh[XLEN-1:0];
    div_next = {rem_new, acc[XLEN-2:0], rem_ge};
  end

  // Sign correction and result select in DONE
  logic [DW-1:0]   prod;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] md_result;
  always_comb begin
    prod = neg_q ? DW'(-acc) : acc;
    quot = neg_q ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem  = neg_r ? XLEN'(-acc[DW-1:XLEN]) : acc[DW-1:XLEN];
    case (md_f3)
      3'b000:                 md_result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_result = prod[DW-1:XLEN];
      3'b100, 3'b101:         md_result = quot;
      default:                md_result = rem;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (bus.clk_en) begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus.i_valid && bus.i_is_md && !bus.i_flush) begin
          state_next = bus.i_funct3[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (bus.i_flush) begin
          state_next = S_IDLE;
        end else if (last_step) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output/control logic; a flush kills whatever the stage holds this cycle
  always_comb begin
    accept   = 1'b0;
    step     = 1'b0;
    stall    = 1'b0;
    valid_d  = 1'b0;
    reg_wr_d = 1'b0;
    result_d = result_q;
    rd_d     = rd_q;
    case (state)
      S_IDLE: begin
        if (bus.i_valid && !bus.i_flush) begin
          if (bus.i_is_md) begin
            accept = 1'b1;
            stall  = 1'b1;
          end else begin
            valid_d  = 1'b1;
            reg_wr_d = bus.i_reg_wr;
            result_d = bus.i_alu_result;
            rd_d     = bus.i_rd;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (!bus.i_flush) begin
          step  = 1'b1;
          stall = 1'b1;
        end
      end
      S_DONE: begin
        // Stall released here so the next instruction loads while this retires
        if (!bus.i_flush) begin
          valid_d  = 1'b1;
          reg_wr_d = md_reg_wr;
          result_d = md_result;
          rd_d     = md_rd;
        end
      end
      default: ;
    endcase
  end

  // Iterative datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      op_b      <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      md_f3     <= '0;
      md_rd     <= '0;
      md_reg_wr <= 1'b0;
    end else if (bus.clk_en) begin
      if (accept) begin
        cnt       <= '0;
        md_f3     <= bus.i_funct3;
        md_rd     <= bus.i_rd;
        md_reg_wr <= bus.i_reg_wr;
        if (bus.i_funct3[2]) begin
          op_b  <= abs_b;
          acc   <= {XLEN'(0), abs_a};
          // Divide by zero keeps the all-ones quotient unsigned-looking
          neg_q <= (a_neg ^ b_neg) & ~b_zero;
          neg_r <= a_neg;
        end else begin
          op_b  <= abs_a;
          acc   <= {XLEN'(0), abs_b};
          neg_q <= a_neg ^ b_neg;
          neg_r <= 1'b0;
        end
      end else if (step) begin
        acc <= (state == S_MUL) ? mul_next : div_next;
        cnt <= last_step ? '0 : cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // EX/MEM register and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      reg_wr_q <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
    end else if (bus.clk_en) begin
      valid_q  <= valid_d;
      reg_wr_q <= reg_wr_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      busy_q   <= (state_next != S_IDLE);
    end
  end

  assign bus.o_stall  = stall;
  assign bus.o_busy   = busy_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_reg_wr = reg_wr_q;
  assign bus.o_result = result_q;
  assign bus.o_rd     = rd_q;

endmodule
